seg7_scan_display: RTL and testbench
====================================

Name: seg7_scan_display

Overview:
- Downstream display stage for the key-driven up/down counter on the Omdazz board.
- Latches a binary value on a valid strobe and converts it to BCD with a sequential double-dabble.
- Drives the 4-digit multiplexed 7-segment display (active-low digit enables and segments) using a scan prescaler.
- Replaces the constant-zero tie-offs on DIG_1..4 / SEG_0..7; the counter output is zero-extended into value.

Parameters:
- W, 14, width of value input; valid range 4..14.
- SCAN_DIV, 50000, FPGA_CLK cycles per digit slot (1 ms at 50 MHz); legal minimum 2.
- BLANK_LZ, 1, 1 = blank leading zero digits; 0 = show all four digits.

Ports:
- FPGA_CLK  in  1  system clock, 50 MHz, all logic on its rising edge.
- RESET_BUT  in  1  reset, asynchronous, active-high.
- value  in  W  unsigned binary value to display.
- value_valid  in  1  one-cycle strobe; value is sampled when high.
- dig_n  out  4  digit enables, active-low; bit 0 = least significant digit.
- seg_n  out  8  segments, active-low; bit0=a … bit6=g, bit7=dp.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when the display register is updated.

Behaviour:
- Reset (async, immediate):
  - Outputs: dig_n=4'hF, seg_n=8'hFF, busy=0, done=0.
  - Internal state: display BCD = 0000, overflow flag=0, scan index=0, prescaler=0, pending flag=0, converter idle.
- Converter FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: on value_valid at edge T, latch value into the shift register, clear the BCD accumulator, set overflow = (value > 9999), go to SHIFT. busy=1 from T+1.
  - SHIFT: W cycles. Each cycle, first add 3 to every BCD nibble ≥5, then shift {bcd,bin} left by 1. Bit counter runs W-1 down to 0.
  - COMMIT: one cycle. Load the display BCD register (or overflow pattern), done=1 for this cycle, busy=0 next cycle.
  - Timing: done is high in cycle T+W+1, and the display register is visible from T+W+2. busy is high for cycles T+1..T+W+1.
- value_valid while busy: the value is stored in a pending register and the pending flag is set. A later strobe overwrites it (last wins). In COMMIT with pending set, the FSM goes directly to SHIFT with the pending value; busy stays high and the pending flag clears.
- value_valid coincident with COMMIT: treated as pending (same path).
- Overflow (value > 9999): all four digits show '-' (segment g only; seg_n=8'hBF). Latency is identical to normal conversion.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 continuously, independent of the converter.
  - On wrap, the scan index increments 0→1→2→3→0.
  - dig_n and seg_n are registered and change on the same edge. dig_n = ~(4'b0001 << index).
- Segment encoding (active-high before inversion):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibbles A–F map to 00 (blank); they cannot occur from a legal conversion.
  - dp always off (seg_n[7]=1).
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k (k=3..1) shows seg_n=8'hFF when it and all higher digits are zero.
  - Digit 0 is always shown.
  - Not applied in overflow.
- The display register changes only in COMMIT. The shown value never shows intermediate conversion data.
- Reset mid-conversion: abort immediately and drop pending. After release, show "0" (digit 0 = 8'hC0, others blank) from the first scan slot.

Test Plan:
- Reset release with SCAN_DIV=4, no strobe -> dig_n cycles E,D,B,7 every 4 clocks; seg_n=C0 on digit 0 and FF on digits 1–3.
- value=13, single strobe at T, W=14 -> busy high T+1..T+15, done at T+15; digit0 seg_n=B0 ('3'), digit1 seg_n=F9 ('1'), digits 2–3 FF.
- value=9999 then value=10000 -> first shows four 'd9' (seg_n=90 on every digit); second shows seg_n=BF on all digits, same latency.
- Strobes of 5, 7, 8 at T, T+3, T+6 -> done at T+15 showing '5'; immediate re-conversion with no idle cycle; done at T+30 showing '8'; 7 never displayed.
- BLANK_LZ=0, value=42 -> digits 3..0 show C0,C0,99,A4 ("0042").
- RESET_BUT asserted at T+8 of a conversion of 1234 -> dig_n=F and seg_n=FF asynchronously, busy=0; after release, shows "0" and no done pulse.

Source files
------------

// File: rtl/seg7_scan_display.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seg7_scan_display
// Display stage for the key-driven up/down counter. A binary value is latched
// on value_valid, converted to four BCD digits by a sequential double-dabble,
// and then shown on a 4-digit multiplexed 7-segment display.
//
// Ports
//   FPGA_CLK    : system clock, all logic on its rising edge
//   RESET_BUT   : asynchronous active-high reset
//   value       : unsigned binary value to display (W bits)
//   value_valid : one-cycle strobe, value sampled when high
//   dig_n       : digit enables, active-low, bit 0 = least significant digit
//   seg_n       : segments, active-low, bit0=a .. bit6=g, bit7=dp
//   busy        : conversion in progress
//   done        : one-cycle pulse in the cycle the display register is loaded
// -----------------------------------------------------------------------------
module seg7_scan_display #(
   parameter int W        = 14,
   parameter int SCAN_DIV = 50000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic         FPGA_CLK,
   input  logic         RESET_BUT,
   input  logic [W-1:0] value,
   input  logic         value_valid,
   output logic [3:0]   dig_n,
   output logic [7:0]   seg_n,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(W);
   localparam int PW = $clog2(SCAN_DIV);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

   // Converter state
   state_t          r_state;
   logic [W-1:0]    r_bin;
   logic [15:0]     r_bcd;
   logic [CW-1:0]   r_bit_cnt;
   logic            r_ovf;
   logic            r_pend;
   logic [W-1:0]    r_pend_val;
   logic            r_busy;
   logic            r_done;

   // Display state
   logic [15:0]     r_disp_bcd;
   logic            r_disp_ovf;
   logic [PW-1:0]   r_presc;
   logic [1:0]      r_idx;
   logic [3:0]      r_dig_n;
   logic [7:0]      r_seg_n;

   // Combinational helpers
   logic [W-1:0]    w_load_val;
   logic [15:0]     w_bcd_adj;
   logic [W+15:0]   w_shift;
   logic [3:0]      w_cur_digit;
   logic [3:0]      w_lead_zero;
   logic [7:0]      w_seg_next;

   // Add 3 to every BCD nibble that is 5 or more, before the shift.
   function automatic logic [15:0] f_dd_adjust(input logic [15:0] bcd);
      logic [15:0] res;
      res = bcd;
      for (int i = 0; i < 4; i++) begin
         if (res[i*4 +: 4] >= 4'd5)
            res[i*4 +: 4] = res[i*4 +: 4] + 4'd3;
      end
      return res;
   endfunction

   function automatic logic f_is_ovf(input logic [W-1:0] v);
      return 32'(v) > 32'd9999;
   endfunction

   // Active-high segment pattern {g,f,e,d,c,b,a}; A-F are blank.
   function automatic logic [6:0] f_seg(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   // A strobe arriving in the same cycle as COMMIT wins over an older pending value.
   assign w_load_val = value_valid ? value : r_pend_val;
   assign w_bcd_adj  = f_dd_adjust(r_bcd);
   assign w_shift    = {w_bcd_adj, r_bin} << 1;

   // -------------------------------------------------------------------------
   // Converter FSM
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
      if (RESET_BUT) begin
         r_state    <= S_IDLE;
         r_bin      <= '0;
         r_bcd      <= '0;
         r_bit_cnt  <= '0;
         r_ovf      <= 1'b0;
         r_pend     <= 1'b0;
         r_pend_val <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_disp_bcd <= '0;
         r_disp_ovf <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (value_valid) begin
                  r_bin     <= value;
                  r_bcd     <= '0;
                  r_ovf     <= f_is_ovf(value);
                  r_bit_cnt <= CW'(W-1);
                  r_busy    <= 1'b1;
                  r_state   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_bcd <= w_shift[W+15:W];
               r_bin <= w_shift[W-1:0];
               if (r_bit_cnt == '0) begin
                  r_done  <= 1'b1;
                  r_state <= S_COMMIT;
               end else begin
                  r_bit_cnt <= r_bit_cnt - CW'(1);
               end
               if (value_valid) begin
                  r_pend     <= 1'b1;
                  r_pend_val <= value;
               end
            end
            S_COMMIT: begin
               r_disp_bcd <= r_bcd;
               r_disp_ovf <= r_ovf;
               if (value_valid || r_pend) begin
                  // Back-to-back conversion: busy stays high, no idle cycle.
                  r_bin     <= w_load_val;
                  r_bcd     <= '0;
                  r_ovf     <= f_is_ovf(w_load_val);
                  r_bit_cnt <= CW'(W-1);
                  r_pend    <= 1'b0;
                  r_state   <= S_SHIFT;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Segment selection for the digit slot currently being scanned
   // -------------------------------------------------------------------------
   // NOTE: every signal gets a default at the top so no path leaves it
   // unassigned, which keeps this purely combinational.
   always_comb begin
      w_cur_digit    = r_disp_bcd[{r_idx, 2'b00} +: 4];
      w_lead_zero    = 4'b0000;
      w_lead_zero[3] = (r_disp_bcd[15:12] == 4'd0);
      w_lead_zero[2] = w_lead_zero[3] && (r_disp_bcd[11:8] == 4'd0);
      w_lead_zero[1] = w_lead_zero[2] && (r_disp_bcd[7:4] == 4'd0);
      w_seg_next     = {1'b1, ~f_seg(w_cur_digit)};
      if (r_disp_ovf)
         w_seg_next = 8'hBF;
      else if (BLANK_LZ && w_lead_zero[r_idx])
         w_seg_next = 8'hFF;
   end

   // -------------------------------------------------------------------------
   // Scan prescaler and registered digit/segment drivers
   // -------------------------------------------------------------------------
   always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
      if (RESET_BUT) begin
         r_presc <= '0;
         r_idx   <= 2'd0;
         r_dig_n <= 4'hF;
         r_seg_n <= 8'hFF;
      end else begin
         if (r_presc == PW'(SCAN_DIV-1)) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
         end else begin
            r_presc <= r_presc + PW'(1);
         end
         r_dig_n <= ~(4'b0001 << r_idx);
         r_seg_n <= w_seg_next;
      end
   end

   assign dig_n = r_dig_n;
   assign seg_n = r_seg_n;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule

// File: tb/tb_seg7_scan_display.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_seg7_scan_display
// Two instances share the inputs: one with leading-zero blanking, one without.
// A reference model at the clock edge predicts when each conversion completes
// and what it shows; a monitor on the falling edge compares done, busy and the
// scanned digit/segment outputs against those expectations.
// -----------------------------------------------------------------------------
module tb_seg7_scan_display;

   localparam int W  = 14;
   localparam int SD = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] value = '0;
   logic         vv = 1'b0;

   logic [3:0] dig_n,  dig_n2;
   logic [7:0] seg_n,  seg_n2;
   logic       busy,   busy2;
   logic       done,   done2;

   always #5 clk = ~clk;

   seg7_scan_display #(.W(W), .SCAN_DIV(SD), .BLANK_LZ(1'b1)) u_dut (
      .FPGA_CLK(clk), .RESET_BUT(rst), .value(value), .value_valid(vv),
      .dig_n(dig_n), .seg_n(seg_n), .busy(busy), .done(done)
   );

   seg7_scan_display #(.W(W), .SCAN_DIV(SD), .BLANK_LZ(1'b0)) u_dut_nb (
      .FPGA_CLK(clk), .RESET_BUT(rst), .value(value), .value_valid(vv),
      .dig_n(dig_n2), .seg_n(seg_n2), .busy(busy2), .done(done2)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Expected segment byte for decimal digit idx of v, straight from the display rules.
   function automatic logic [7:0] ref_seg(input int v, input int idx, input bit blank);
      int p;
      int d;
      logic [6:0] pat;
      if (v > 9999) return 8'hBF;
      p = 1;
      for (int i = 0; i < idx; i++) p = p * 10;
      d = (v / p) % 10;
      if (blank && idx > 0 && v < p) return 8'hFF;
      case (d)
         0: pat = 7'h3F;  1: pat = 7'h06;  2: pat = 7'h5B;  3: pat = 7'h4F;
         4: pat = 7'h66;  5: pat = 7'h6D;  6: pat = 7'h7D;  7: pat = 7'h07;
         8: pat = 7'h7F;  default: pat = 7'h6F;
      endcase
      return {1'b1, ~pat};
   endfunction

   // ---------------------------------------------------------------------------
   // Reference model: one conversion takes W+1 cycles; strobes during a
   // conversion leave only the latest value pending, started right at commit.
   // ---------------------------------------------------------------------------
   typedef struct {
      int done_edge;
      int val;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   k = 0;
   bit   m_active = 1'b0;
   bit   m_pend = 1'b0;
   int   m_commit = 0;
   int   m_pend_v = 0;

   task automatic start_conv(input int v);
      exp_t e;
      m_active    = 1'b1;
      m_commit    = cyc + W + 1;
      e.done_edge = cyc + W;
      e.val       = v;
      q.push_back(e);
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         k        = 0;
         m_active = 1'b0;
         m_pend   = 1'b0;
         q.delete();
      end else begin
         cyc++;
         k++;
         if (!m_active) begin
            if (vv) start_conv(int'(value));
         end else if (cyc == m_commit) begin
            if (vv)          start_conv(int'(value));
            else if (m_pend) start_conv(m_pend_v);
            else             m_active = 1'b0;
            m_pend = 1'b0;
         end else if (vv) begin
            m_pend   = 1'b1;
            m_pend_v = int'(value);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   int exp_disp = 0;
   int pend_cnt = 0;
   int pend_val = 0;

   always @(negedge clk) begin : mon
      int         idx;
      logic [3:0] ed;
      bit         exp_done;
      exp_t       e;
      if (rst) begin
         exp_disp = 0;
         pend_cnt = 0;
      end else begin
         // New value reaches the pins two edges after the done cycle.
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) exp_disp = pend_val;
         end
         if (k == 0) begin
            check("dig_n_idle", dig_n, 4'hF);
            check("seg_n_idle", seg_n, 8'hFF);
         end else begin
            idx = ((k - 1) / SD) % 4;
            ed  = ~(4'b0001 << idx);
            check("dig_n", dig_n, ed);
            check("seg_n", seg_n, ref_seg(exp_disp, idx, 1'b1));
            check("dig_n_nb", dig_n2, ed);
            check("seg_n_nb", seg_n2, ref_seg(exp_disp, idx, 1'b0));
         end
         check("busy", busy, m_active);
         check("busy_nb", busy2, m_active);
         exp_done = (q.size() > 0) && (q[0].done_edge == cyc);
         check("done", done, exp_done);
         check("done_nb", done2, exp_done);
         if (exp_done) begin
            e        = q.pop_front();
            pend_val = e.val;
            pend_cnt = 2;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   // Called at a falling edge; one-cycle strobe, returns `spacing` cycles later.
   task automatic send(input int v, input int spacing);
      value = W'(v);
      vv    = 1'b1;
      @(negedge clk);
      vv = 1'b0;
      repeat (spacing - 1) @(negedge clk);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || q.size() > 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", n < 500, 1'b1);
      repeat (4*SD + 4) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      repeat (4*SD + 4) @(negedge clk);

      send(13, 1);     wait_idle();
      send(9999, 1);   wait_idle();
      send(10000, 1);  wait_idle();
      send(5, 3); send(7, 3); send(8, 1);  wait_idle();
      send(42, 1);     wait_idle();
      send(0, 1);      wait_idle();
      send(16383, 1);  wait_idle();
      // Second strobe lands exactly in the COMMIT cycle of the first.
      send(100, W + 1); send(200, 1);  wait_idle();

      for (int i = 0; i < 30; i++) begin
         send(int'($urandom_range(0, 16383)), int'($urandom_range(1, 24)));
         if ($urandom_range(0, 3) == 0) wait_idle();
      end
      wait_idle();

      // Reset in the middle of a conversion of 1234.
      send(1234, 8);
      #2 rst = 1'b1;
      #1;
      check("rst_dig_n", dig_n, 4'hF);
      check("rst_seg_n", seg_n, 8'hFF);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_dig_n_nb", dig_n2, 4'hF);
      check("rst_seg_n_nb", seg_n2, 8'hFF);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      repeat (4*SD + 24) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
